// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: word widths, special
// instruction encodings and the fetch-stage state type.
package mips_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_WORD_DEF  = '0;
    localparam logic [INSTR_W-1:0] HALT_WORD_DEF = '1;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold and flush controls.
// Flush has priority over Hold: a flush loads a NOP bubble and keeps PCPlus4.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Hold,
    input  logic               Flush,
    input  logic [INSTR_W-1:0] InstrIn,
    input  logic [WORD_W-1:0]  PCPlus4In,
    output logic [INSTR_W-1:0] InstrOut,
    output logic [WORD_W-1:0]  PCPlus4Out,
    output logic               ValidOut
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0]  pc_plus4_q, pc_plus4_d;
    logic               valid_q, valid_d;

    // Select next register contents: flush bubble, hold, or load.
    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (Flush) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else if (!Hold) begin
            instr_d    = InstrIn;
            pc_plus4_d = PCPlus4In;
            valid_d    = 1'b1;
        end
    end

    // Register update with synchronous reset to an empty slot.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            instr_q    <= NOP_WORD;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign InstrOut   = instr_q;
    assign PCPlus4Out = pc_plus4_q;
    assign ValidOut   = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, the BOOT/RUN/HALTED control,
// the fetch counter and the sticky alignment error, and feeds IF/ID.
module if_stage
    import mips_pkg::*;
#(
    parameter int unsigned        IMEM_AW   = 10,
    parameter logic [WORD_W-1:0]  RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEF,
    parameter logic [INSTR_W-1:0] NOP_WORD  = NOP_WORD_DEF
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Stall,
    input  logic               Redirect,
    input  logic [WORD_W-1:0]  RedirectPC,
    output logic [IMEM_AW-1:0] ImemAddr,
    input  logic [INSTR_W-1:0] ImemData,
    output logic [WORD_W-1:0]  PC,
    output logic [INSTR_W-1:0] IF_ID_Instruction,
    output logic [WORD_W-1:0]  IF_ID_PCPlus4,
    output logic               IF_ID_Valid,
    output logic               Halted,
    output logic               AlignErr,
    output logic [WORD_W-1:0]  FetchCount
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic              halted_q, halted_d;
    logic              align_err_q, align_err_d;
    logic [WORD_W-1:0] fetch_count_q, fetch_count_d;

    logic [WORD_W-1:0] pc_plus4;
    logic              id_hold;
    logic              id_flush;

    assign pc_plus4 = pc_q + 32'd4;

    // Next-state, PC, counter and IF/ID control decisions.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        halted_d      = halted_q;
        align_err_d   = align_err_q;
        fetch_count_d = fetch_count_q;
        id_hold       = 1'b0;
        id_flush      = 1'b0;
        case (state_q)
            BOOT: begin
                id_flush = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                if (Redirect) begin
                    pc_d     = {RedirectPC[WORD_W-1:2], 2'b00};
                    id_flush = 1'b1;
                    if (RedirectPC[1:0] != 2'b00) align_err_d = 1'b1;
                end else if (Stall) begin
                    id_hold = 1'b1;
                end else begin
                    // The halt word itself is accepted into IF/ID; only the PC freezes.
                    fetch_count_d = fetch_count_q + 32'd1;
                    if (ImemData == HALT_WORD) begin
                        halted_d = 1'b1;
                        state_d  = HALTED;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            HALTED: begin
                if (Redirect) begin
                    pc_d     = {RedirectPC[WORD_W-1:2], 2'b00};
                    id_flush = 1'b1;
                    halted_d = 1'b0;
                    state_d  = RUN;
                    if (RedirectPC[1:0] != 2'b00) align_err_d = 1'b1;
                end else if (Stall) begin
                    id_hold = 1'b1;
                end else begin
                    id_flush = 1'b1;
                end
            end
            default: begin
                id_flush = 1'b1;
                state_d  = BOOT;
            end
        endcase
    end

    // State, PC and status registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            halted_q      <= 1'b0;
            align_err_q   <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            halted_q      <= halted_d;
            align_err_q   <= align_err_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id_reg (
        .Clk        (Clk),
        .Rst        (Rst),
        .Hold       (id_hold),
        .Flush      (id_flush),
        .InstrIn    (ImemData),
        .PCPlus4In  (pc_plus4),
        .InstrOut   (IF_ID_Instruction),
        .PCPlus4Out (IF_ID_PCPlus4),
        .ValidOut   (IF_ID_Valid)
    );

    assign ImemAddr   = pc_q[IMEM_AW+1:2];
    assign PC         = pc_q;
    assign Halted     = halted_q;
    assign AlignErr   = align_err_q;
    assign FetchCount = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: vector table plus hand-built
// halt/reset sequences, checked through an expectation queue.
module tb_if_stage;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] pc;
        logic        halted;
        logic        align;
        logic [31:0] cnt;
    } vec_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = '0;
    logic [9:0]  ImemAddr;
    logic [31:0] ImemData;
    logic [31:0] PC;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        Halted;
    logic        AlignErr;
    logic [31:0] FetchCount;

    logic [31:0] imem [0:1023];
    vec_t        exp_q[$];
    vec_t        tbl [17];
    int          total = 0;
    int          bad   = 0;
    int          step_no = 0;

    always #5 Clk = ~Clk;

    assign ImemData = imem[ImemAddr];

    if_stage #(
        .IMEM_AW   (10),
        .RESET_PC  (32'h0000_0000),
        .HALT_WORD (32'hFFFF_FFFF),
        .NOP_WORD  (32'h0000_0000)
    ) dut (
        .Clk               (Clk),
        .Rst               (Rst),
        .Stall             (Stall),
        .Redirect          (Redirect),
        .RedirectPC        (RedirectPC),
        .ImemAddr          (ImemAddr),
        .ImemData          (ImemData),
        .PC                (PC),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PCPlus4     (IF_ID_PCPlus4),
        .IF_ID_Valid       (IF_ID_Valid),
        .Halted            (Halted),
        .AlignErr          (AlignErr),
        .FetchCount        (FetchCount)
    );

    function automatic vec_t mk(input logic rst, input logic stall, input logic redir,
                                input logic [31:0] rpc, input logic [31:0] instr,
                                input logic [31:0] pc4, input logic valid,
                                input logic [31:0] pc, input logic halted,
                                input logic align, input logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.stall = stall; v.redir = redir; v.rpc = rpc;
        v.instr = instr; v.pc4 = pc4; v.valid = valid; v.pc = pc;
        v.halted = halted; v.align = align; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, step_no, got, want);
        end
    endtask

    // Drive one vector, queue its expectation, then compare after the edge.
    task automatic step(input vec_t v);
        vec_t e;
        logic [31:0] exp_pc;
        @(negedge Clk);
        Rst        = v.rst;
        Stall      = v.stall;
        Redirect   = v.redir;
        RedirectPC = v.rpc;
        exp_q.push_back(v);
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        exp_pc = e.pc;
        check("instr",    IF_ID_Instruction, e.instr);
        check("pcplus4",  IF_ID_PCPlus4,     e.pc4);
        check("valid",    {31'd0, IF_ID_Valid}, {31'd0, e.valid});
        check("pc",       PC,                e.pc);
        check("imemaddr", {22'd0, ImemAddr}, {22'd0, exp_pc[11:2]});
        check("halted",   {31'd0, Halted},   {31'd0, e.halted});
        check("alignerr", {31'd0, AlignErr}, {31'd0, e.align});
        check("fetchcnt", FetchCount,        e.cnt);
        step_no++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog step=%0d got=timeout want=finish", step_no);
        $fatal(1, "bench did not finish");
    end

    initial begin
        for (int k = 0; k < 1024; k++) imem[k] = 32'(k + 1);

        // Reset state, then BOOT with Stall/Redirect asserted (ignored).
        step(mk(1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'd0));

        tbl[0]  = mk(0, 1, 1, 32'h43, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'd0);
        tbl[1]  = mk(0, 0, 0, 32'h0, 32'd1, 32'd4, 1, 32'd4, 0, 0, 32'd1);
        tbl[2]  = mk(0, 0, 0, 32'h0, 32'd2, 32'd8, 1, 32'd8, 0, 0, 32'd2);
        tbl[3]  = mk(0, 1, 0, 32'h0, 32'd2, 32'd8, 1, 32'd8, 0, 0, 32'd2);
        tbl[4]  = mk(0, 1, 0, 32'h0, 32'd2, 32'd8, 1, 32'd8, 0, 0, 32'd2);
        tbl[5]  = mk(0, 1, 0, 32'h0, 32'd2, 32'd8, 1, 32'd8, 0, 0, 32'd2);
        tbl[6]  = mk(0, 0, 0, 32'h0, 32'd3, 32'd12, 1, 32'd12, 0, 0, 32'd3);
        tbl[7]  = mk(0, 0, 0, 32'h0, 32'd4, 32'd16, 1, 32'd16, 0, 0, 32'd4);
        tbl[8]  = mk(0, 1, 1, 32'h40, 32'h0, 32'd16, 0, 32'h40, 0, 0, 32'd4);
        tbl[9]  = mk(0, 0, 0, 32'h0, 32'd17, 32'h44, 1, 32'h44, 0, 0, 32'd5);
        tbl[10] = mk(0, 0, 1, 32'h43, 32'h0, 32'h44, 0, 32'h40, 0, 1, 32'd5);
        tbl[11] = mk(0, 0, 0, 32'h0, 32'd17, 32'h44, 1, 32'h44, 0, 1, 32'd6);
        tbl[12] = mk(0, 0, 1, 32'h8, 32'h0, 32'h44, 0, 32'h8, 0, 1, 32'd6);
        tbl[13] = mk(0, 0, 0, 32'h0, 32'd3, 32'd12, 1, 32'd12, 0, 1, 32'd7);
        tbl[14] = mk(0, 0, 1, 32'hFFFF_FFFC, 32'h0, 32'd12, 0, 32'hFFFF_FFFC, 0, 1, 32'd7);
        tbl[15] = mk(0, 0, 0, 32'h0, 32'd1024, 32'h0, 1, 32'h0, 0, 1, 32'd8);
        tbl[16] = mk(0, 0, 0, 32'h0, 32'd1, 32'd4, 1, 32'd4, 0, 1, 32'd9);

        for (int i = 0; i < 17; i++) step(tbl[i]);

        // Halt sequence: reset clears AlignErr, halt word at word 2.
        imem[2] = 32'hFFFF_FFFF;
        step(mk(1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'd0));
        step(mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'd0));
        step(mk(0, 0, 0, 32'h0, 32'd1, 32'd4, 1, 32'd4, 0, 0, 32'd1));
        step(mk(0, 0, 0, 32'h0, 32'd2, 32'd8, 1, 32'd8, 0, 0, 32'd2));
        step(mk(0, 0, 0, 32'h0, 32'hFFFF_FFFF, 32'd12, 1, 32'd8, 1, 0, 32'd3));
        step(mk(0, 1, 0, 32'h0, 32'hFFFF_FFFF, 32'd12, 1, 32'd8, 1, 0, 32'd3));
        step(mk(0, 0, 0, 32'h0, 32'h0, 32'd12, 0, 32'd8, 1, 0, 32'd3));
        step(mk(0, 0, 0, 32'h0, 32'h0, 32'd12, 0, 32'd8, 1, 0, 32'd3));
        step(mk(0, 0, 1, 32'h0, 32'h0, 32'd12, 0, 32'h0, 0, 0, 32'd3));
        step(mk(0, 0, 0, 32'h0, 32'd1, 32'd4, 1, 32'd4, 0, 0, 32'd4));
        step(mk(0, 0, 0, 32'h0, 32'd2, 32'd8, 1, 32'd8, 0, 0, 32'd5));
        step(mk(0, 0, 0, 32'h0, 32'hFFFF_FFFF, 32'd12, 1, 32'd8, 1, 0, 32'd6));
        // Reset while halted and stalled overrides everything.
        step(mk(1, 1, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'd0));
        step(mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'd0));
        step(mk(0, 0, 0, 32'h0, 32'd1, 32'd4, 1, 32'd4, 0, 0, 32'd1));

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL queue_drain got=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS datapath.
- Owns the PC and drives the word address to instruction memory.
- Registers the fetched word and PC+4 toward the decode controller.
- Handles stalls, branch/jump redirects with flush, and halt detection.

Parameters:
- IMEM_AW, 10, instruction-memory word-address width (depth 2**IMEM_AW words).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.
- NOP_WORD, 32'h0000_0000, word placed in IF/ID on bubble or flush.

Ports:
- Clk, input, 1, clock; all state updates on the rising edge.
- Rst, input, 1, synchronous, active-high reset.
- Stall, input, 1, hazard unit request to hold the PC and IF/ID.
- Redirect, input, 1, taken branch or jump resolved downstream.
- RedirectPC, input, 32, target byte address for Redirect.
- ImemAddr, output, IMEM_AW, word address = PC[IMEM_AW+1:2]; combinational from the PC register.
- ImemData, input, 32, asynchronous-read instruction word at ImemAddr.
- PC, output, 32, current fetch PC.
- IF_ID_Instruction, output, 32, registered instruction to decode.
- IF_ID_PCPlus4, output, 32, registered PC+4 of that instruction.
- IF_ID_Valid, output, 1, IF/ID holds a real instruction.
- Halted, output, 1, fetch stopped on HALT_WORD.
- AlignErr, output, 1, sticky; set when RedirectPC[1:0] != 0.
- FetchCount, output, 32, count of instructions accepted into IF/ID; wraps 2^32-1 -> 0.

Behaviour:
- Reset (Rst=1 at edge):
  - PC=RESET_PC; IF_ID_Instruction=NOP_WORD; IF_ID_PCPlus4=0; IF_ID_Valid=0.
  - Halted=0; AlignErr=0; FetchCount=0; state=BOOT.
  - Rst overrides all other inputs, including mid-stall or mid-halt.
- State machine: BOOT, RUN, HALTED.
  - BOOT: one bubble cycle. PC holds. IF/ID = NOP with Valid=0. Next state is RUN unconditionally, even with Stall or Redirect asserted; those inputs are ignored in BOOT.
- RUN, priority per edge is Redirect > Stall > normal:
  - Redirect: PC <= {RedirectPC[31:2],2'b00}. IF/ID flushed (NOP_WORD, Valid=0, PCPlus4 unchanged). FetchCount unchanged. If RedirectPC[1:0] != 0, AlignErr <= 1.
  - Stall (no Redirect): PC, IF/ID and FetchCount all hold.
  - Normal fetch with ImemData != HALT_WORD: PC <= PC+4 (32-bit wrap). IF_ID_Instruction <= ImemData; IF_ID_PCPlus4 <= PC+4; Valid <= 1; FetchCount += 1.
  - Normal fetch with ImemData == HALT_WORD: halt word loaded into IF/ID with Valid=1; FetchCount += 1. PC holds. Halted <= 1. State -> HALTED.
- HALTED:
  - PC holds; Halted=1.
  - Each non-stalled cycle loads IF/ID with NOP, Valid=0.
  - Stall holds IF/ID, so a halt word already in IF/ID stays there until the stall releases.
  - Redirect: same action as in RUN, plus Halted <= 0 and state -> RUN. This covers a halt fetched on a wrong path.
- Latency:
  - Instruction at PC appears on IF_ID_* one edge after the PC is presented.
  - Redirect target's instruction is valid in IF/ID two edges after Redirect is sampled, i.e. one bubble.
- ImemAddr wraps modulo the memory depth. PC itself is never truncated.
- AlignErr clears only on Rst.

Decomposition:
- Shared package mips_pkg holds: NOP_WORD, HALT_WORD defaults, the state enum (BOOT/RUN/HALTED), and the 32-bit instruction/word widths.
- One sub-module is natural: if_id_reg. It is the pipeline register with hold (Stall) and flush (load NOP, Valid=0) controls.
- if_stage keeps the PC, the FSM and the counter.

Test Plan:
- Reset then free-run, with imem[k]=k+1 for k=0..3:
  - Edge 1 after reset: Valid=0 (BOOT).
  - Edges 2..5: IF_ID_Instruction = 1,2,3,4; PCPlus4 = 4,8,12,16; FetchCount = 4.
- Stall held 3 cycles after instruction 2 is in IF/ID:
  - Instruction stays 2, PC stays 8, FetchCount stays 2.
  - After release, next value is 3.
- Redirect and Stall asserted together, RedirectPC=0x40:
  - Next edge: PC=0x40, Valid=0.
  - Following edge: IF_ID_Instruction=imem[16], PCPlus4=0x44.
- Misaligned redirect, RedirectPC=0x43:
  - PC=0x40 and AlignErr=1.
  - AlignErr stays 1 through later redirects until Rst.
- imem[2]=HALT_WORD:
  - Halt word enters IF/ID with Valid=1; Halted=1; PC stays 8; subsequent Valid=0.
  - Then Redirect to 0x0: Halted=0, fetch resumes with imem[0].
- PC near wrap: RedirectPC=0xFFFF_FFFC with IMEM_AW=10:
  - ImemAddr=1023.
  - Next PC=0x0000_0000 and PCPlus4=0.
  - Rst during HALTED returns PC=RESET_PC and Halted=0.
